// File: rtl/mesh_link_pipe.sv
// mesh_link_pipe: multi-channel link register pipeline with power-gate isolation, flush and re-arm
module mesh_link_pipe #(
  parameter int DEPTH = 2,
  parameter int NCH = 2,
  parameter int ID_W = 6,
  parameter int QOS_W = 1,
  parameter int TYPE_W = 2,
  parameter int DATA_W = 64,
  parameter logic [ID_W-1:0] NEAR_ID = ID_W'(0),
  parameter logic [ID_W-1:0] FAR_ID = ID_W'(1),
  parameter int REARM_CYC = 4,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pg_en,
  input  logic [ID_W-1:0]              pg_node,
  input  logic [NCH-1:0]               in_vld,
  input  logic [NCH*QOS_W-1:0]         in_qos,
  input  logic [NCH*TYPE_W-1:0]        in_type,
  input  logic [NCH*ID_W-1:0]          in_src,
  input  logic [NCH*ID_W-1:0]          in_tgt,
  input  logic [NCH*DATA_W-1:0]        in_data,
  output logic [NCH-1:0]               out_vld,
  output logic [NCH*QOS_W-1:0]         out_qos,
  output logic [NCH*TYPE_W-1:0]        out_type,
  output logic [NCH*ID_W-1:0]          out_src,
  output logic [NCH*ID_W-1:0]          out_tgt,
  output logic [NCH*DATA_W-1:0]        out_data,
  output logic [1:0]                   link_state,
  output logic [$clog2(NCH*DEPTH+1)-1:0] inflight,
  output logic [CNT_W-1:0]             drop_cnt
);
  localparam int PW = QOS_W + TYPE_W + 2 * ID_W + DATA_W;
  localparam int IW = $clog2(NCH * DEPTH + 1);
  localparam int CW = $clog2(NCH + 1);
  localparam int SW = CNT_W + IW + 1;
  typedef enum logic [1:0] {LIVE = 2'd0, DEAD = 2'd1, REARM = 2'd2} state_t;
  state_t r_state, w_nstate;
  logic [7:0] r_rearm, w_nrearm;
  logic [NCH-1:0] r_vld [DEPTH];
  logic [NCH*PW-1:0] r_pay [DEPTH];
  logic [NCH*PW-1:0] w_in_pay;
  logic [CNT_W-1:0] r_drop, w_drop_nxt;
  logic [IW-1:0] w_stage_cnt;
  logic [CW-1:0] w_in_cnt;
  logic [IW:0] w_in_ext, w_inc;
  logic [SW-1:0] w_sum;
  logic w_fault, w_far, w_take, w_deliver;
  assign w_fault = pg_en && (pg_node == NEAR_ID || pg_node == FAR_ID);
  assign w_far = pg_en && pg_node == FAR_ID;
  assign w_take = r_state == LIVE && !w_fault;
  assign w_deliver = w_take;
  assign link_state = r_state;
  assign inflight = w_stage_cnt;
  assign drop_cnt = r_drop;
  assign w_in_ext = (IW+1)'(w_in_cnt);
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign w_in_pay[c*PW +: PW] = {in_qos[c*QOS_W +: QOS_W], in_type[c*TYPE_W +: TYPE_W],
                                   in_src[c*ID_W +: ID_W], in_tgt[c*ID_W +: ID_W], in_data[c*DATA_W +: DATA_W]};
    assign out_vld[c] = r_vld[DEPTH-1][c] & w_deliver;
    assign {out_qos[c*QOS_W +: QOS_W], out_type[c*TYPE_W +: TYPE_W], out_src[c*ID_W +: ID_W],
            out_tgt[c*ID_W +: ID_W], out_data[c*DATA_W +: DATA_W]} = out_vld[c] ? r_pay[DEPTH-1][c*PW +: PW] : '0;
  end
  // popcounts of occupied stages and of offered input flits
  always_comb begin
    w_stage_cnt = '0;
    w_in_cnt = '0;
    for (int k = 0; k < DEPTH; k++)
      for (int c = 0; c < NCH; c++)
        w_stage_cnt = w_stage_cnt + IW'(r_vld[k][c]);
    for (int c = 0; c < NCH; c++)
      w_in_cnt = w_in_cnt + CW'(in_vld[c]);
  end
  // drops: flushed stages on fault entry, plus input that had nowhere to go
  always_comb begin
    w_inc = r_state == LIVE ? (w_fault ? {1'b0, w_stage_cnt} + (w_far ? w_in_ext : '0) : '0) :
            r_state == DEAD ? (w_far ? w_in_ext : '0) :
            r_state == REARM ? w_in_ext : '0;
    w_sum = SW'(r_drop) + SW'(w_inc);
    w_drop_nxt = w_sum > SW'({CNT_W{1'b1}}) ? '1 : w_sum[CNT_W-1:0];
  end
  // link state next-state logic
  always_comb begin
    w_nstate = r_state;
    w_nrearm = r_rearm;
    case (r_state)
      LIVE: w_nstate = w_fault ? DEAD : LIVE;
      DEAD: begin
        w_nstate = w_fault ? DEAD : REARM;
        w_nrearm = w_fault ? r_rearm : 8'(REARM_CYC - 1);
      end
      REARM: begin
        w_nstate = w_fault ? DEAD : (r_rearm == 8'd0 ? LIVE : REARM);
        w_nrearm = (w_fault || r_rearm == 8'd0) ? r_rearm : r_rearm - 8'd1;
      end
      default: w_nstate = LIVE;
    endcase
  end
  // state, rearm counter and drop counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LIVE;
      r_rearm <= '0;
      r_drop <= '0;
    end else begin
      r_state <= w_nstate;
      r_rearm <= w_nrearm;
      r_drop <= w_drop_nxt;
    end
  end
  // stage valids shift while live; any fault or non-live state empties the pipe
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) r_vld[k] <= '0;
    end else begin
      r_vld[0] <= w_take ? in_vld : '0;
      for (int k = 1; k < DEPTH; k++) r_vld[k] <= w_take ? r_vld[k-1] : '0;
    end
  end
  // payload shifts unconditionally; it is only observed behind a valid bit
  always_ff @(posedge clk) begin
    r_pay[0] <= w_in_pay;
    for (int k = 1; k < DEPTH; k++) r_pay[k] <= r_pay[k-1];
  end
endmodule

// File: tb/tb_mesh_link_pipe.sv
// tb_mesh_link_pipe: timestamped-history model plus directed literal checks for mesh_link_pipe
module tb_mesh_link_pipe;
  localparam int DEPTH = 3, NCH = 2, ID_W = 6, CNT_W = 4, RC = 4, PW = 79;
  localparam logic [5:0] NEAR = 6'd9, FAR = 6'd10;
  logic clk = 0, rst = 1, pg_en = 0;
  logic [5:0] pg_node = 0;
  logic [1:0] in_vld = 0, in_qos = 0, out_vld, out_qos;
  logic [3:0] in_type = 0, out_type;
  logic [11:0] in_src = 0, in_tgt = 0, out_src, out_tgt;
  logic [127:0] in_data = 0, out_data;
  logic [1:0] link_state;
  logic [2:0] inflight;
  logic [3:0] drop_cnt;
  int checks = 0, errors = 0;
  mesh_link_pipe #(.DEPTH(DEPTH), .NCH(NCH), .ID_W(ID_W), .QOS_W(1), .TYPE_W(2), .DATA_W(64),
    .NEAR_ID(NEAR), .FAR_ID(FAR), .REARM_CYC(RC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .pg_en(pg_en), .pg_node(pg_node), .in_vld(in_vld), .in_qos(in_qos),
    .in_type(in_type), .in_src(in_src), .in_tgt(in_tgt), .in_data(in_data), .out_vld(out_vld),
    .out_qos(out_qos), .out_type(out_type), .out_src(out_src), .out_tgt(out_tgt), .out_data(out_data),
    .link_state(link_state), .inflight(inflight), .drop_cnt(drop_cnt));
  always #5 clk = ~clk;
  int m = -1, last_clear = -1, mode = 0, rem = 0, drop = 0;
  logic [1:0] acc_v [0:1023];
  logic [PW-1:0] acc_p [0:1023][0:1];
  function automatic int pop2(input logic [1:0] v);
    return int'(v[0]) + int'(v[1]);
  endfunction
  function automatic int infl(input int k);
    int s = 0;
    for (int e = k - DEPTH + 1; e <= k; e++)
      if (e >= 0 && e > last_clear) s += pop2(acc_v[e]);
    return s;
  endfunction
  function automatic logic fault();
    return pg_en && (pg_node == NEAR || pg_node == FAR);
  endfunction
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    m++;
    acc_v[m] = 0;
    if (rst) begin
      mode = 0; drop = 0; rem = 0; last_clear = m;
    end else if (mode == 0) begin
      if (fault()) begin
        drop += infl(m - 1) + ((pg_en && pg_node == FAR) ? pop2(in_vld) : 0);
        mode = 1; last_clear = m;
      end else begin
        acc_v[m] = in_vld;
        for (int c = 0; c < 2; c++)
          acc_p[m][c] = {in_qos[c], in_type[c*2 +: 2], in_src[c*6 +: 6], in_tgt[c*6 +: 6], in_data[c*64 +: 64]};
      end
    end else if (mode == 1) begin
      if (pg_en && pg_node == FAR) drop += pop2(in_vld);
      if (!fault()) begin mode = 2; rem = RC; end
    end else begin
      drop += pop2(in_vld);
      if (fault()) mode = 1;
      else begin rem--; if (rem == 0) mode = 0; end
    end
    if (drop > 15) drop = 15;
  end
  always begin
    @(negedge clk);
    #2;
    if (m >= 0) begin
      int e;
      logic [1:0] ev;
      e = m - DEPTH + 1;
      ev = (e >= 0 && e > last_clear && mode == 0 && !fault()) ? acc_v[e] : 2'b00;
      chk("out_vld", out_vld, ev);
      for (int c = 0; c < 2; c++)
        chk("payload", {out_qos[c], out_type[c*2 +: 2], out_src[c*6 +: 6], out_tgt[c*6 +: 6], out_data[c*64 +: 64]},
            ev[c] ? acc_p[e][c] : '0);
      chk("inflight", inflight, infl(m));
      chk("link_state", link_state, mode);
      chk("drop_cnt", drop_cnt, drop);
    end
  end
  task automatic cyc(input logic r, input logic [1:0] v, input logic [7:0] s, input logic pe, input logic [5:0] pn);
    @(negedge clk);
    rst = r; pg_en = pe; pg_node = pn; in_vld = v;
    for (int c = 0; c < 2; c++) begin
      in_data[c*64 +: 64] = {8'hD0, 40'h0, s, 8'(c)};
      in_qos[c] = s[0] ^ c[0];
      in_type[c*2 +: 2] = s[1:0] + 2'(c);
      in_src[c*6 +: 6] = s[5:0] + 6'(c);
      in_tgt[c*6 +: 6] = ~s[5:0];
    end
  endtask
  initial begin
    cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0);
    for (int s = 1; s <= 10; s++) begin
      cyc(0, 3, 8'(s), 0, 0);
      if (s == 4) begin
        #3;
        chk("lat_data", out_data[63:0], 64'hD000000000000100);
        chk("lat_vld", out_vld, 2'b11);
        chk("steady_inflight", inflight, 6);
      end
    end
    repeat (4) cyc(0, 0, 0, 0, 0);
    #3 chk("nofault_drop", drop_cnt, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 3, 1, 0, 0); cyc(0, 3, 2, 0, 0); cyc(0, 1, 3, 0, 0);
    cyc(0, 3, 4, 1, FAR);
    #3 chk("far_inflight", inflight, 5);
    chk("far_mask", out_vld, 2'b00);
    cyc(0, 0, 0, 1, FAR);
    #3 chk("far_drop", drop_cnt, 7);
    chk("far_dead", link_state, 1);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 3, 1, 0, 0); cyc(0, 3, 2, 0, 0);
    cyc(0, 3, 3, 1, NEAR);
    #3 chk("near_inflight", inflight, 4);
    cyc(0, 3, 4, 1, NEAR);
    #3 chk("near_drop", drop_cnt, 4);
    chk("near_dead", link_state, 1);
    cyc(0, 3, 5, 1, NEAR); cyc(0, 3, 5, 1, NEAR);
    #3 chk("near_nocount", drop_cnt, 4);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 6, 0, 0);
    #3 chk("rearm1", link_state, 2);
    cyc(0, 0, 0, 1, NEAR);
    cyc(0, 0, 0, 1, NEAR);
    #3 chk("redead", link_state, 1);
    chk("rearm_drop", drop_cnt, 5);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0);
      #3 chk("rearm_hold", link_state, 2);
    end
    cyc(0, 3, 8'h20, 0, 0);
    #3 chk("live_again", link_state, 0);
    cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
    #3 chk("first_vld", out_vld, 2'b11);
    chk("first_data", out_data[127:64], 64'hD000000000002001);
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 3, 8'(i), 1, FAR);
    cyc(0, 0, 0, 1, FAR);
    #3 chk("sat", drop_cnt, 15);
    cyc(0, 3, 1, 1, FAR);
    cyc(0, 0, 0, 1, FAR);
    #3 chk("sat_hold", drop_cnt, 15);
    repeat (7) cyc(0, 0, 0, 0, 0);
    cyc(0, 3, 1, 0, 0); cyc(0, 3, 2, 0, 0); cyc(0, 3, 3, 0, 0);
    #3 chk("pre_rst_drop", drop_cnt, 15);
    chk("pre_rst_inflight", inflight, 4);
    cyc(1, 3, 9, 0, 0);
    cyc(0, 0, 0, 0, 0);
    #3 chk("rst_vld", out_vld, 0);
    chk("rst_data", out_data, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_state", link_state, 0);
    chk("rst_inflight", inflight, 0);
    repeat (4) cyc(0, 0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mesh_link_pipe.md
# mesh_link_pipe

Parametrised inter-node link pipeline for the 8x8 maze mesh, sitting between one node's C-interface output and its neighbour's C-interface input. It carries NCH independent packet channels (X and Y by default) through DEPTH register stages, sized per link by Manhattan distance. It also isolates the link when either end node is power-gated via pg_en/pg_node: it flushes in-flight packets, counts drops and re-arms after the fault clears.

## Interface
- DEPTH, 2: register stages per channel, legal 1..8.
- NCH, 2: channel count (0 = X, 1 = Y), legal 1..4.
- ID_W, 6: node coordinate width, {vp[2:0],hp[2:0]}.
- QOS_W, 1 / TYPE_W, 2 / DATA_W, 64: payload field widths.
- NEAR_ID, 0: coordinate of the driving node.
- FAR_ID, 1: coordinate of the receiving node.
- REARM_CYC, 4: cycles spent in REARM, legal 1..255.
- CNT_W, 16: drop counter width.
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- pg_en  in  1  fault enable.
- pg_node  in  ID_W  faulty node coordinate.
- in_vld  in  NCH  per-channel valid.
- in_qos / in_type / in_src / in_tgt / in_data  in  NCH*field width  packed per channel; channel c occupies slice [c*W +: W].
- out_vld, out_qos, out_type, out_src, out_tgt, out_data  out  same widths  delivered packets.
- link_state  out  2  0 = LIVE, 1 = DEAD, 2 = REARM.
- inflight  out  $clog2(NCH*DEPTH+1)  popcount of valid stage bits.
- drop_cnt  out  CNT_W  saturating count of discarded packets.

## Operation
- fault_now = pg_en && (pg_node == NEAR_ID || pg_node == FAR_ID). This is combinational.
- far_dead = pg_en && pg_node == FAR_ID.
- No backpressure (the C interface has no ready). Stages shift every cycle.
- LIVE:
  - Stage 0 captures in_vld and payload. Stage k captures stage k-1. out_* is driven from stage DEPTH-1.
  - If fault_now is sampled at an edge, clear all stage valid bits, do not capture input, and move to DEAD.
  - drop_cnt += popcount(all stage valids) + (far_dead ? popcount(in_vld) : 0). Input from a dead near end is garbage and is not counted.
- DEAD:
  - Input is ignored and the pipeline stays empty.
  - Each cycle with far_dead, drop_cnt += popcount(in_vld).
  - If !fault_now at an edge, load the rearm counter with REARM_CYC-1 and move to REARM.
- REARM:
  - Input is ignored and counted as drops (popcount(in_vld)).
  - If fault_now, go to DEAD.
  - Otherwise, when the counter reaches 0, go to LIVE; else decrement.
  - The first input accepted is on the cycle link_state reads LIVE.
- drop_cnt saturates at all-ones; an increment that would overflow clamps.
- out_vld = last-stage valid & (link_state == LIVE) & ~fault_now. Delivery never happens to a dead node, even on the detection cycle; that flit is counted by the flush.
- Output payload is forced to zero for any channel with out_vld = 0.
- Channels are fully independent, with no reordering within a channel.

## Timing
- Latency in LIVE is exactly DEPTH cycles: input sampled at edge t appears on out_* after edge t+DEPTH-1. Throughput is 1 packet per channel per cycle.
- Fault detection:
  - out_vld is masked in the same cycle fault_now rises.
  - The flush and the DEAD state take effect at the next edge.
  - drop_cnt updates at that edge.
- Recovery: from the edge fault_now is seen low in DEAD, link_state reads REARM for exactly REARM_CYC cycles, then LIVE.
- Reset values: link_state = LIVE, all stage valids 0, out_* = 0, inflight = 0, drop_cnt = 0, rearm counter 0.
- rst overrides fault and counters. Reset mid-flight discards packets without counting them.
- A pg_node change between NEAR_ID and FAR_ID while pg_en stays high keeps the link DEAD; the counting rule follows the current far_dead.
- inflight is registered popcount and reads 0 in DEAD and REARM.

## Test plan
- DEPTH=3, NCH=2, no fault. Drive X and Y back-to-back for 10 cycles with distinct data. Required: identical sequences out 3 cycles later, inflight = 6 in steady state, drop_cnt = 0.
- FAR_ID fault with 5 flits in flight and in_vld = 2'b11 on the detection cycle. Required: out_vld 0 that cycle, drop_cnt = 7 next cycle, link_state = DEAD.
- NEAR_ID fault with 4 flits in flight and in_vld = 2'b11. Required: drop_cnt = 4. Further in_vld in DEAD is not counted.
- REARM_CYC=4: clear pg_en, then reassert on the 2nd REARM cycle. Required: back to DEAD. On a second clear, LIVE exactly 4 cycles later, and the first packet appears DEPTH cycles after that.
- CNT_W=4, far end dead, in_vld = 2'b11 for 10 cycles. Required: drop_cnt saturates at 15 and holds.
- Assert rst mid-stream in LIVE with flits in flight. Required: next cycle all outputs 0, drop_cnt 0, link_state LIVE.
